// File: rtl/exp2_pkg.sv
// Shared definitions for the sequential power-of-two decoder.
//   state_t   : decoder FSM states (IDLE / SHIFT / DONE)
//   WIDTH_DEF : default one-hot output width
//   PW_DEF    : default power input width
package exp2_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int unsigned WIDTH_DEF = 8;
   localparam int unsigned PW_DEF    = 3;

endpackage

// File: rtl/exp2_seq_if.sv
// Handshake bundle for exp2_seq.
//   in_valid/in_ready/power           : request channel (master -> slave)
//   out_valid/out_ready/value/range_err : result channel (slave -> master)
//   busy                              : slave status, high while a decode is in flight
// modport master : the producer/consumer side (bench or upstream logic)
// modport slave  : the decoder side
interface exp2_seq_if
   import exp2_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF,
   parameter int unsigned PW    = PW_DEF
) ();

   logic             in_valid;
   logic             in_ready;
   logic [PW-1:0]    power;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] value;
   logic             range_err;
   logic             busy;

   modport master (
      output in_valid, power, out_ready,
      input  in_ready, out_valid, value, range_err, busy
   );

   modport slave (
      input  in_valid, power, out_ready,
      output in_ready, out_valid, value, range_err, busy
   );

endinterface

// File: rtl/exp2_seq.sv
// Sequential power-of-two decoder: accepts a PW-bit exponent and produces the
// WIDTH-bit one-hot value 2^power, built by one left shift per clock.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous reset, active-low
//   bus   : exp2_seq_if.slave (in_valid/in_ready/power, out_valid/out_ready/
//           value/range_err, busy)
// Powers >= WIDTH complete immediately with value=0 and range_err=1.
module exp2_seq
   import exp2_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF,
   parameter int unsigned PW    = PW_DEF
) (
   input logic       clk,
   input logic       rst_n,
   exp2_seq_if.slave bus
);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] value_q;
   logic [PW-1:0]    cnt;
   logic             range_err_q;
   logic             power_oor;
   logic             accept;

   assign power_oor = 32'(bus.power) >= WIDTH;
   assign accept    = (state == IDLE) && bus.in_valid;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (bus.in_valid) begin
               if (power_oor || (bus.power == '0)) state_nxt = DONE;
               else                                state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            // cnt==1 here means the shift on this edge is the last one
            if (cnt == PW'(1)) state_nxt = DONE;
         end
         DONE: begin
            if (bus.out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Shift register, down-counter and error flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value_q     <= '0;
         cnt         <= '0;
         range_err_q <= 1'b0;
      end else if (accept) begin
         if (power_oor) begin
            value_q     <= '0;
            cnt         <= '0;
            range_err_q <= 1'b1;
         end else begin
            value_q     <= WIDTH'(1);
            cnt         <= bus.power;
            range_err_q <= 1'b0;
         end
      end else if (state == SHIFT) begin
         value_q <= value_q << 1;
         cnt     <= cnt - PW'(1);
      end
   end

   // Output logic
   always_comb begin
      bus.in_ready  = (state == IDLE);
      bus.out_valid = (state == DONE);
      bus.busy      = (state == SHIFT) || (state == DONE);
      bus.value     = value_q;
      bus.range_err = range_err_q;
   end

endmodule

// File: doc/exp2_seq.md
Name: exp2_seq

Overview:
- Sequential power-of-two decoder: takes a 3-bit exponent, returns the 8-bit one-hot value 2^power.
- It is the inverse of the team's one-hot-to-exponent encoder, and round-trips with it.
- The value is built iteratively: one left shift per clock, behind valid/ready handshakes on input and output.
- Used wherever an exponent stream must be expanded back into one-hot masks, for example lane/bank select.

Parameters:
- WIDTH, 8, bit width of the one-hot output value.
- PW, 3, bit width of the power input. Must satisfy 2^PW >= WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- in_valid  input  1  power is valid.
- in_ready  output  1  block can accept a new power.
- power  input  PW  exponent to decode.
- out_valid  output  1  value is valid.
- out_ready  input  1  consumer accepts value.
- value  output  WIDTH  one-hot result 2^power, or all-zero on range error.
- range_err  output  1  qualified by out_valid; set when power >= WIDTH.
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- Reset: asynchronous assert, synchronous-safe release. While rst_n is low:
  - state=IDLE, value=0, cnt=0, range_err=0.
  - out_valid=0, busy=0, in_ready=1.
- Reset mid-operation aborts the decode silently. No output is produced for the aborted power.
- FSM has three states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On a clock edge with in_valid=1, the power is accepted.
  - If power >= WIDTH: value<=0, range_err<=1, go to DONE.
  - Otherwise value<=1 (bit 0 only), cnt<=power, range_err<=0.
  - Then go to DONE if power==0, else SHIFT.
- SHIFT:
  - in_ready=0.
  - Each edge: value<=value<<1, cnt<=cnt-1.
  - When cnt==1 at the edge, go to DONE.
- DONE:
  - out_valid=1; value and range_err are held stable.
  - On an edge with out_ready=1, go to IDLE.
  - in_ready stays 0 in DONE. There is no same-cycle bypass or back-to-back acceptance.
- Latency: out_valid rises p+1 cycles after the accept edge for power=p (1 cycle for p=0, 8 cycles for p=7).
- Throughput: at best one result per p+2 cycles.
- Backpressure: if out_ready is held low, DONE holds indefinitely and value does not change.
- in_valid and power are ignored outside IDLE. Inputs sampled only at the accept edge matter; later changes have no effect.
- value is always either exactly one bit set or all-zero (all-zero only with range_err=1).
- cnt is PW bits wide; no wrap-around is possible because it only decrements while nonzero.
- With the defaults (WIDTH=8, PW=3), range_err is never set.

Decomposition:
- Shared package exp2_pkg holds:
  - the state enum (IDLE/SHIFT/DONE);
  - localparams WIDTH_DEF=8 and PW_DEF=3.
- No sub-module: a single FSM with a shift register and a down-counter.
- The existing encoder is instantiated only in the bench, as the round-trip checker.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles -> out_valid=0, in_ready=1, value=8'h00, busy=0.
- Sweep: power=0..7, out_ready=1 -> value=8'h01,02,04,08,10,20,40,80. out_valid rises at 1,2,...,8 cycles after accept. Encoder round-trip returns the original power.
- Backpressure: power=5, out_ready=0 for 10 cycles -> value=8'h20 held stable, in_ready=0. Raise out_ready -> IDLE next cycle, in_ready=1.
- Ignored input: accept power=6, then drive in_valid=1 with power=2 during SHIFT -> result 8'h40, and the second request is accepted only after return to IDLE.
- Reset mid-operation: accept power=7, pull rst_n low after 3 cycles -> outputs immediately at reset values. After release there is no stale out_valid.
- Range error: instantiate with WIDTH=6, PW=3, power=6 -> out_valid after 1 cycle, value=6'h00, range_err=1.
